inst_queue: RTL and testbench

- Dual-write, dual-read instruction FIFO between instruction fetch and the issue (launch) stage.
- Absorbs 0–2 fetched {pc, inst} pairs per cycle from IF.
- Presents the oldest two entries as line1 and line2 to issue.
- Retires 0, 1 or 2 entries per cycle, as reported by issue. This decouples single/double-issue stalls from fetch.

---
 rtl/inst_queue_pkg.sv | 35 +++
 rtl/inst_queue_if.sv | 41 ++++
 rtl/inst_queue_ram.sv | 42 ++++
 rtl/inst_queue.sv | 176 +++++++++++++++++
 tb/tb_inst_queue.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/inst_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue_pkg
// Brief    : Shared constants, entry layout and occupancy state for inst_queue.
// Revision : 1.0 - initial release
// ============================================================================
package inst_queue_pkg;

    localparam int INST_Q_DEPTH  = 8;
    localparam int INST_Q_DATA_W = 64;

    // Entry layout: {pc, inst}
    localparam int PC_MSB   = 63;
    localparam int PC_LSB   = 32;
    localparam int INST_MSB = 31;
    localparam int INST_LSB = 0;

    // Two-slot buses toward IF and issue, {line2_data, line1_data}
    localparam int InstQInBusWidth  = 2 * INST_Q_DATA_W;
    localparam int InstQOutBusWidth = 2 * INST_Q_DATA_W;

    localparam int POP_CNT_W = 2;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL2   = 2'd2
    } q_state_e;

    function automatic logic [PC_MSB-PC_LSB:0] entry_pc(input logic [INST_Q_DATA_W-1:0] e);
        return e[PC_MSB:PC_LSB];
    endfunction

endpackage : inst_queue_pkg
`default_nettype wire

// File: rtl/inst_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue_if
// Brief    : IF-side push and issue-side pop/flush signals of the instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_queue_if
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = INST_Q_DEPTH,
    parameter int DATA_W = INST_Q_DATA_W
);
    localparam int PTR_W = $clog2(DEPTH);

    logic                   line1_in_valid_i;
    logic                   line2_in_valid_i;
    logic [2*DATA_W-1:0]    in_bus_i;
    logic                   in_allowin_o;
    logic                   line1_out_valid_o;
    logic                   line2_out_valid_o;
    logic [2*DATA_W-1:0]    out_bus_o;
    logic [POP_CNT_W-1:0]   pop_cnt_i;
    logic                   branch_flush_i;
    logic                   excep_flush_i;
    logic [PTR_W:0]         count_o;

    // Environment side: fetch pushes, issue pops and flushes
    modport master (
        output line1_in_valid_i, line2_in_valid_i, in_bus_i,
        output pop_cnt_i, branch_flush_i, excep_flush_i,
        input  in_allowin_o, line1_out_valid_o, line2_out_valid_o, out_bus_o, count_o
    );

    modport slave (
        input  line1_in_valid_i, line2_in_valid_i, in_bus_i,
        input  pop_cnt_i, branch_flush_i, excep_flush_i,
        output in_allowin_o, line1_out_valid_o, line2_out_valid_o, out_bus_o, count_o
    );

endinterface : inst_queue_if
`default_nettype wire

// File: rtl/inst_queue_ram.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue_ram
// Brief    : DEPTH x DATA_W storage, two write ports, two asynchronous reads.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue_ram #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              i_we0,
    input  wire logic [PTR_W-1:0]  i_waddr0,
    input  wire logic [DATA_W-1:0] i_wdata0,
    input  wire logic              i_we1,
    input  wire logic [PTR_W-1:0]  i_waddr1,
    input  wire logic [DATA_W-1:0] i_wdata1,
    input  wire logic [PTR_W-1:0]  i_raddr0,
    output logic      [DATA_W-1:0] o_rdata0,
    input  wire logic [PTR_W-1:0]  i_raddr1,
    output logic      [DATA_W-1:0] o_rdata1
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage is deliberately left unreset; occupancy masks stale contents.
    // The two write addresses are always distinct (consecutive slots).
    always_ff @(posedge clk) begin
        if (i_we0) begin
            r_mem[i_waddr0] <= i_wdata0;
        end
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule : inst_queue_ram
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Brief    : Dual-push / dual-pop instruction FIFO between fetch and issue.
//            Define INST_QUEUE_BYPASS_EN for zero-latency pass-through when empty.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = INST_Q_DEPTH,
    parameter int DATA_W = INST_Q_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  wire logic    clk,
    input  wire logic    rst,
    inst_queue_if.slave  q_if
);

    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]     r_rptr;
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W:0]       r_count;

    logic [PTR_W-1:0]     w_rptr_next;
    logic [PTR_W-1:0]     w_wptr_next;
    logic [PTR_W:0]       w_count_next;

    q_state_e             w_state;
    logic                 w_allowin;
    logic                 w_flush;
    logic                 w_bypass;
    logic [1:0]           w_push_n;
    logic [1:0]           w_wr_n;
    logic [PTR_W:0]       w_pop_avail;
    logic [POP_CNT_W-1:0] w_eff_pop;
    logic [POP_CNT_W-1:0] w_pop_mem;
    logic [POP_CNT_W-1:0] w_pop_byp;

    logic [DATA_W-1:0]    w_in_line1;
    logic [DATA_W-1:0]    w_in_line2;
    logic [DATA_W-1:0]    w_cmp0;
    logic [DATA_W-1:0]    w_cmp1;
    logic                 w_we0;
    logic                 w_we1;
    logic [DATA_W-1:0]    w_wdata0;
    logic [DATA_W-1:0]    w_rdata0;
    logic [DATA_W-1:0]    w_rdata1;
    logic                 w_out_v1;
    logic                 w_out_v2;
    logic [DATA_W-1:0]    w_out_d1;
    logic [DATA_W-1:0]    w_out_d2;

    assign w_flush    = q_if.branch_flush_i | q_if.excep_flush_i;
    assign w_in_line1 = q_if.in_bus_i[DATA_W-1:0];
    assign w_in_line2 = q_if.in_bus_i[2*DATA_W-1:DATA_W];

    // Occupancy state comes from the registered count only, so allowin never
    // depends on the same-cycle pop from issue.
    always_comb begin
        w_state = Q_PARTIAL;
        if (r_count == '0) begin
            w_state = Q_EMPTY;
        end else if ((c_depth - r_count) < (PTR_W+1)'(2)) begin
            w_state = Q_FULL2;
        end
    end

    assign w_allowin = (w_state != Q_FULL2);
    assign w_push_n  = w_allowin
                     ? ({1'b0, q_if.line1_in_valid_i} + {1'b0, q_if.line2_in_valid_i})
                     : 2'd0;

    // Line2-only input slides down into the first free slot.
    assign w_cmp0 = q_if.line1_in_valid_i ? w_in_line1 : w_in_line2;
    assign w_cmp1 = w_in_line2;

`ifdef INST_QUEUE_BYPASS_EN
    assign w_bypass = (w_state == Q_EMPTY) && !w_flush;
`else
    assign w_bypass = 1'b0;
`endif

    // Entries visible to issue this cycle: stored ones, or incoming ones when bypassing.
    assign w_pop_avail = w_bypass ? (PTR_W+1)'(w_push_n) : r_count;

    always_comb begin
        w_eff_pop = q_if.pop_cnt_i;
        if ((PTR_W+1)'(q_if.pop_cnt_i) > w_pop_avail) begin
            w_eff_pop = w_pop_avail[POP_CNT_W-1:0];
        end
    end

    assign w_pop_mem = w_bypass ? '0 : w_eff_pop;
    assign w_pop_byp = w_bypass ? w_eff_pop : '0;

    // Bypassed entries already consumed by issue are never written.
    assign w_wr_n   = w_push_n - w_pop_byp;
    assign w_we0    = !w_flush && (w_wr_n != 2'd0);
    assign w_we1    = !w_flush && (w_wr_n == 2'd2);
    assign w_wdata0 = (w_pop_byp == 2'd1) ? w_cmp1 : w_cmp0;

    always_comb begin
        w_rptr_next  = r_rptr + PTR_W'(w_pop_mem);
        w_wptr_next  = r_wptr + PTR_W'(w_wr_n);
        w_count_next = r_count + (PTR_W+1)'(w_wr_n) - (PTR_W+1)'(w_pop_mem);
        if (w_flush) begin
            w_rptr_next  = '0;
            w_wptr_next  = '0;
            w_count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_rptr  <= w_rptr_next;
            r_wptr  <= w_wptr_next;
            r_count <= w_count_next;
        end
    end

    inst_queue_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk      (clk),
        .i_we0    (w_we0),
        .i_waddr0 (r_wptr),
        .i_wdata0 (w_wdata0),
        .i_we1    (w_we1),
        .i_waddr1 (r_wptr + PTR_W'(1)),
        .i_wdata1 (w_cmp1),
        .i_raddr0 (r_rptr),
        .o_rdata0 (w_rdata0),
        .i_raddr1 (r_rptr + PTR_W'(1)),
        .o_rdata1 (w_rdata1)
    );

    always_comb begin
        w_out_v1 = (r_count >= (PTR_W+1)'(1));
        w_out_v2 = (r_count >= (PTR_W+1)'(2));
        w_out_d1 = w_rdata0;
        w_out_d2 = w_rdata1;
        if (w_bypass) begin
            w_out_v1 = (w_push_n != 2'd0);
            w_out_v2 = (w_push_n == 2'd2);
            w_out_d1 = w_cmp0;
            w_out_d2 = w_cmp1;
        end
    end

    assign q_if.in_allowin_o      = w_allowin;
    assign q_if.line1_out_valid_o = w_out_v1;
    assign q_if.line2_out_valid_o = w_out_v2;
    assign q_if.out_bus_o         = {(w_out_v2 ? w_out_d2 : '0), (w_out_v1 ? w_out_d1 : '0)};
    assign q_if.count_o           = r_count;

`ifndef SYNTHESIS
    // Issue asking for more than is available is an upstream bug; RTL clamps it.
    always_ff @(posedge clk) begin
        if (!rst && !w_flush) begin
            assert ((PTR_W+1)'(q_if.pop_cnt_i) <= w_pop_avail)
                else $warning("inst_queue: pop_cnt %0d exceeds available %0d, clamped",
                              q_if.pop_cnt_i, w_pop_avail);
        end
    end
`endif

endmodule : inst_queue
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue
// Brief    : Directed self-checking bench for inst_queue (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    inst_queue_if q_if ();

    inst_queue dut (
        .clk  (clk),
        .rst  (rst),
        .q_if (q_if)
    );

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {pc, pc ^ 32'h0bad_f00d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v1, input logic v2,
                         input logic [31:0] pc1, input logic [31:0] pc2,
                         input logic [1:0] pop, input logic bf, input logic ef);
        q_if.line1_in_valid_i = v1;
        q_if.line2_in_valid_i = v2;
        q_if.in_bus_i         = {ent(pc2), ent(pc1)};
        q_if.pop_cnt_i        = pop;
        q_if.branch_flush_i   = bf;
        q_if.excep_flush_i    = ef;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] push_pc [4];
        push_pc[0] = 32'h1c00_0120;
        push_pc[1] = 32'h1c00_0120;
        push_pc[2] = 32'h1c00_0128;
        push_pc[3] = 32'h1c00_0130;

        // Reset then idle
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count",   64'(q_if.count_o), 64'd0);
        chk("rst_allowin", 64'(q_if.in_allowin_o), 64'd1);
        chk("rst_v1",      64'(q_if.line1_out_valid_o), 64'd0);
        chk("rst_v2",      64'(q_if.line2_out_valid_o), 64'd0);
        chk("rst_bus_lo",  q_if.out_bus_o[63:0], 64'd0);
        chk("rst_bus_hi",  q_if.out_bus_o[127:64], 64'd0);

        // Dual push then single pop
        drive(1'b1, 1'b1, 32'h1c00_0000, 32'h1c00_0004, 2'd0, 1'b0, 1'b0);
        chk("push_same_cycle_v1", 64'(q_if.line1_out_valid_o), 64'd0);
        tick();
        idle();
        chk("dual_v1",    64'(q_if.line1_out_valid_o), 64'd1);
        chk("dual_v2",    64'(q_if.line2_out_valid_o), 64'd1);
        chk("dual_pc1",   64'(q_if.out_bus_o[63:32]), 64'h1c00_0000);
        chk("dual_line2", q_if.out_bus_o[127:64], ent(32'h1c00_0004));
        chk("dual_count", 64'(q_if.count_o), 64'd2);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        tick();
        idle();
        chk("pop1_pc1",   64'(q_if.out_bus_o[63:32]), 64'h1c00_0004);
        chk("pop1_v2",    64'(q_if.line2_out_valid_o), 64'd0);
        chk("pop1_bus2",  q_if.out_bus_o[127:64], 64'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        tick();
        idle();
        chk("drain_count", 64'(q_if.count_o), 64'd0);

        // Fill to DEPTH starting from a non-zero pointer so the write wraps
        for (int k = 0; k < 4; k++) begin
            chk("fill_allowin", 64'(q_if.in_allowin_o), 64'd1);
            drive(1'b1, 1'b1, 32'h1c00_0100 + 32'(8*k), 32'h1c00_0104 + 32'(8*k),
                  2'd0, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("full_count",   64'(q_if.count_o), 64'd8);
        chk("full_allowin", 64'(q_if.in_allowin_o), 64'd0);
        drive(1'b1, 1'b1, 32'h1c00_0200, 32'h1c00_0204, 2'd0, 1'b0, 1'b0);
        tick();
        idle();
        chk("ignored_count", 64'(q_if.count_o), 64'd8);
        chk("ignored_head",  64'(q_if.out_bus_o[63:32]), 64'h1c00_0100);

        // Pop 2 while pushing; the first push is refused and held by fetch
        for (int j = 0; j < 4; j++) begin
            chk("stream_allowin", 64'(q_if.in_allowin_o), (j == 0) ? 64'd0 : 64'd1);
            chk("stream_pc1", 64'(q_if.out_bus_o[63:32]), 64'h1c00_0100 + 64'(8*j));
            chk("stream_pc2", 64'(q_if.out_bus_o[127:96]), 64'h1c00_0104 + 64'(8*j));
            drive(1'b1, 1'b1, push_pc[j], push_pc[j] + 32'd4, 2'd2, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("stream_count", 64'(q_if.count_o), 64'd6);
        for (int j = 0; j < 3; j++) begin
            chk("wrap_pc1", 64'(q_if.out_bus_o[63:32]), 64'h1c00_0120 + 64'(8*j));
            chk("wrap_pc2", 64'(q_if.out_bus_o[127:96]), 64'h1c00_0124 + 64'(8*j));
            drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("wrap_empty", 64'(q_if.count_o), 64'd0);

        // Compaction of a line2-only push
        drive(1'b0, 1'b1, 32'h1c00_00ff, 32'h1c00_0040, 2'd0, 1'b0, 1'b0);
        tick();
        idle();
        chk("cmp_pc1",   64'(q_if.out_bus_o[63:32]), 64'h1c00_0040);
        chk("cmp_count", 64'(q_if.count_o), 64'd1);
        chk("cmp_v2",    64'(q_if.line2_out_valid_o), 64'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        tick();

        // Flush beats same-cycle push and pop
        drive(1'b1, 1'b1, 32'h1c00_0300, 32'h1c00_0304, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h1c00_0308, 32'h1c00_030c, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h1c00_0310, 32'h0, 2'd0, 1'b0, 1'b0);
        tick();
        idle();
        chk("pre_flush_count", 64'(q_if.count_o), 64'd5);
        drive(1'b1, 1'b1, 32'h1c00_0314, 32'h1c00_0318, 2'd2, 1'b1, 1'b0);
        tick();
        idle();
        chk("flush_count",   64'(q_if.count_o), 64'd0);
        chk("flush_v1",      64'(q_if.line1_out_valid_o), 64'd0);
        chk("flush_allowin", 64'(q_if.in_allowin_o), 64'd1);
        drive(1'b1, 1'b1, 32'h1c00_0320, 32'h1c00_0324, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        tick();
        idle();
        chk("excep_count", 64'(q_if.count_o), 64'd0);
        chk("excep_bus",   q_if.out_bus_o[63:0], 64'd0);

        // Over-pop is clamped to the single available entry
        drive(1'b1, 1'b0, 32'h1c00_0400, 32'h0, 2'd0, 1'b0, 1'b0);
        tick();
        idle();
        chk("op_pre_count", 64'(q_if.count_o), 64'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        tick();
        idle();
        chk("op_count", 64'(q_if.count_o), 64'd0);
        drive(1'b1, 1'b1, 32'h1c00_0500, 32'h1c00_0504, 2'd0, 1'b0, 1'b0);
        tick();
        idle();
        chk("op_rptr_pc1", 64'(q_if.out_bus_o[63:32]), 64'h1c00_0500);
        chk("op_rptr_pc2", 64'(q_if.out_bus_o[127:96]), 64'h1c00_0504);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_inst_queue
`default_nettype wire
